// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle sequencer: FSM states, opcodes,
// ALU operations and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB,
        MEM_WR, BRANCH, JAL, JALR, LUI, AUIPC, HALT
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU_R / ALU_I tell the datapath to decode the operation from funct3/funct7.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_R   = 4'd2;
    localparam logic [3:0] ALU_I   = 4'd3;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_REG = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU_OUT = 2'b10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_eval.sv
// Branch condition from funct3 and the flags of rs1-rs2; carry=1 means no borrow.
module branch_eval
    import mc_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       carry_i,
    input  logic       sign_i,
    input  logic       overflow_i,
    output logic       taken_o,
    output logic       illegal_o
);

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = zero_i;
            F3_BNE:  taken_o = !zero_i;
            F3_BLT:  taken_o = sign_i ^ overflow_i;
            F3_BGE:  taken_o = !(sign_i ^ overflow_i);
            F3_BLTU: taken_o = !carry_i;
            F3_BGEU: taken_o = carry_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: owns pc/old_pc/instr/retired and steers an external
// datapath whose result bus is the result_src-selected value.
module multicycle_sequencer
    import mc_pkg::*;
#(
    parameter int unsigned     XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR    = 32'h1000,
    parameter bit              HALT_ON_ILLEGAL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic [31:0]     mem_rdata,
    input  logic [XLEN-1:0] result,
    input  logic            alu_zero,
    input  logic            alu_carry,
    input  logic            alu_sign,
    input  logic            alu_overflow,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] old_pc,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] retired,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      result_src,
    output logic [2:0]      imm_src,
    output logic [3:0]      alu_op,
    output logic            reg_write,
    output logic            halted,
    output logic            illegal
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, old_pc_q, old_pc_d, retired_q, retired_d;
    logic [31:0]     instr_q, instr_d;
    logic [6:0]      opcode;
    logic            retire, br_taken, br_illegal;

    assign opcode = instr_q[6:0];

    branch_eval u_branch_eval (
        .funct3_i   (instr_q[14:12]),
        .zero_i     (alu_zero),
        .carry_i    (alu_carry),
        .sign_i     (alu_sign),
        .overflow_i (alu_overflow),
        .taken_o    (br_taken),
        .illegal_o  (br_illegal)
    );

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_VECTOR;
            old_pc_q  <= '0;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            old_pc_q  <= old_pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        old_pc_d   = old_pc_q;
        instr_d    = instr_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        result_src = RES_ALU_REG;
        imm_src    = IMM_I;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;

        // Strobes stay quiet while reset is held, abandoning any pending access.
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc_q;
                    if (mem_ready) begin
                        instr_d  = mem_rdata;
                        old_pc_d = pc_q;
                        pc_d     = pc_q + XLEN'(4);
                        state_d  = DECODE;
                    end
                end
                DECODE: begin
                    alu_src_a = SRC_A_OLD_PC;
                    alu_src_b = SRC_B_IMM;
                    imm_src   = IMM_B;
                    case (opcode)
                        OP_R:               state_d = EXEC_R;
                        OP_IMM:             state_d = EXEC_I;
                        OP_LOAD, OP_STORE:  state_d = MEM_ADR;
                        OP_BRANCH:          state_d = BRANCH;
                        OP_JAL:             state_d = JAL;
                        OP_JALR:            state_d = JALR;
                        OP_LUI:             state_d = LUI;
                        OP_AUIPC:           state_d = AUIPC;
                        default: begin
                            illegal = 1'b1;
                            if (HALT_ON_ILLEGAL) begin
                                state_d = HALT;
                            end else begin
                                retire  = 1'b1;
                                state_d = FETCH;
                            end
                        end
                    endcase
                end
                EXEC_R: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_RS2;
                    alu_op    = ALU_R;
                    state_d   = ALU_WB;
                end
                EXEC_I: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                    imm_src   = IMM_I;
                    alu_op    = ALU_I;
                    state_d   = ALU_WB;
                end
                LUI: begin
                    alu_src_a = SRC_A_ZERO;
                    alu_src_b = SRC_B_IMM;
                    imm_src   = IMM_U;
                    state_d   = ALU_WB;
                end
                AUIPC: begin
                    alu_src_a = SRC_A_OLD_PC;
                    alu_src_b = SRC_B_IMM;
                    imm_src   = IMM_U;
                    state_d   = ALU_WB;
                end
                ALU_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    state_d   = FETCH;
                    // Jumps link old_pc+4, computed fresh since alu_reg holds the target.
                    if (opcode == OP_JAL || opcode == OP_JALR) begin
                        alu_src_a  = SRC_A_OLD_PC;
                        alu_src_b  = SRC_B_FOUR;
                        result_src = RES_ALU_OUT;
                    end
                end
                MEM_ADR: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                    imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                    state_d   = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
                end
                MEM_RD: begin
                    mem_req  = 1'b1;
                    mem_addr = result;
                    if (mem_ready) state_d = MEM_WB;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    result_src = RES_MEM;
                    retire     = 1'b1;
                    state_d    = FETCH;
                end
                MEM_WR: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = result;
                    if (mem_ready) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                end
                BRANCH: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_RS2;
                    alu_op    = ALU_SUB;
                    if (br_illegal) begin
                        illegal = 1'b1;
                        if (HALT_ON_ILLEGAL) begin
                            state_d = HALT;
                        end else begin
                            retire  = 1'b1;
                            state_d = FETCH;
                        end
                    end else begin
                        if (br_taken) pc_d = result;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                end
                JAL: begin
                    alu_src_a  = SRC_A_OLD_PC;
                    alu_src_b  = SRC_B_IMM;
                    imm_src    = IMM_J;
                    result_src = RES_ALU_OUT;
                    pc_d       = result;
                    state_d    = ALU_WB;
                end
                JALR: begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_IMM;
                    imm_src    = IMM_I;
                    result_src = RES_ALU_OUT;
                    pc_d       = {result[XLEN-1:1], 1'b0};
                    state_d    = ALU_WB;
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: state_d = FETCH;
            endcase
        end

        retired_d = retire ? retired_q + XLEN'(1) : retired_q;
    end

    assign pc      = pc_q;
    assign old_pc  = old_pc_q;
    assign instr   = instr_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: three sequencer instances (halting, NOP-on-illegal, wrap-vector)
// share one stimulus stream; the bench plays the datapath by driving result/flags.
module tb_multicycle_sequencer;

    logic        clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
    logic        alu_zero = 1'b0, alu_carry = 1'b0, alu_sign = 1'b0, alu_overflow = 1'b0;
    logic [31:0] mem_rdata = '0, result = '0;

    logic        req_a, we_a, rw_a, hlt_a, ill_a;
    logic [31:0] addr_a, pc_a, opc_a, instr_a, ret_a;
    logic [1:0]  sa_a, sb_a, rs_a;
    logic [2:0]  imm_a;
    logic [3:0]  op_a;

    logic        req_n, we_n, rw_n, hlt_n, ill_n;
    logic [31:0] addr_n, pc_n, opc_n, instr_n, ret_n;
    logic [1:0]  sa_n, sb_n, rs_n;
    logic [2:0]  imm_n;
    logic [3:0]  op_n;

    logic        req_w, we_w, rw_w, hlt_w, ill_w;
    logic [31:0] addr_w, pc_w, opc_w, instr_w, ret_w;
    logic [1:0]  sa_w, sb_w, rs_w;
    logic [2:0]  imm_w;
    logic [3:0]  op_w;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .result(result),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign), .alu_overflow(alu_overflow),
        .pc(pc_a), .old_pc(opc_a), .instr(instr_a), .retired(ret_a),
        .alu_src_a(sa_a), .alu_src_b(sb_a), .result_src(rs_a), .imm_src(imm_a), .alu_op(op_a),
        .reg_write(rw_a), .halted(hlt_a), .illegal(ill_a)
    );

    multicycle_sequencer #(.HALT_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .reset(reset), .mem_req(req_n), .mem_we(we_n), .mem_addr(addr_n),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .result(result),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign), .alu_overflow(alu_overflow),
        .pc(pc_n), .old_pc(opc_n), .instr(instr_n), .retired(ret_n),
        .alu_src_a(sa_n), .alu_src_b(sb_n), .result_src(rs_n), .imm_src(imm_n), .alu_op(op_n),
        .reg_write(rw_n), .halted(hlt_n), .illegal(ill_n)
    );

    multicycle_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .mem_req(req_w), .mem_we(we_w), .mem_addr(addr_w),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .result(result),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign), .alu_overflow(alu_overflow),
        .pc(pc_w), .old_pc(opc_w), .instr(instr_w), .retired(ret_w),
        .alu_src_a(sa_w), .alu_src_b(sb_w), .result_src(rs_w), .imm_src(imm_w), .alu_op(op_w),
        .reg_write(rw_w), .halted(hlt_w), .illegal(ill_w)
    );

    typedef struct {
        logic [2:0] f3;
        logic       z, c, s, v;
        logic       taken;
    } br_vec_t;

    br_vec_t br_tab [7];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] pc_exp, pc_next;

    initial begin
        br_tab[0] = '{f3: 3'b000, z: 1'b1, c: 1'b0, s: 1'b0, v: 1'b0, taken: 1'b1}; // beq taken
        br_tab[1] = '{f3: 3'b000, z: 1'b0, c: 1'b0, s: 1'b0, v: 1'b0, taken: 1'b0}; // beq not taken
        br_tab[2] = '{f3: 3'b001, z: 1'b0, c: 1'b1, s: 1'b0, v: 1'b0, taken: 1'b1}; // bne
        br_tab[3] = '{f3: 3'b100, z: 1'b0, c: 1'b0, s: 1'b1, v: 1'b0, taken: 1'b1}; // blt
        br_tab[4] = '{f3: 3'b101, z: 1'b0, c: 1'b0, s: 1'b1, v: 1'b0, taken: 1'b0}; // bge
        br_tab[5] = '{f3: 3'b110, z: 1'b0, c: 1'b0, s: 1'b0, v: 1'b0, taken: 1'b1}; // bltu
        br_tab[6] = '{f3: 3'b111, z: 1'b0, c: 1'b0, s: 1'b0, v: 1'b1, taken: 1'b0}; // bgeu

        // Reset state, with mem_ready high to show reset wins.
        reset = 1'b1;
        mem_ready = 1'b1;
        cyc();
        cyc();
        check("rst_pc", pc_a, 32'h0000_1000);
        check("rst_old_pc", opc_a, 32'h0);
        check("rst_instr", instr_a, 32'h0);
        check("rst_retired", ret_a, 32'h0);
        check("rst_mem_req", {31'b0, req_a}, 32'h0);
        check("rst_halted_illegal", {30'b0, hlt_a, ill_a}, 32'h0);
        check("rst_selects", {20'b0, sa_a, sb_a, rs_a, imm_a, op_a, rw_a}, 32'h0);
        check("rst_wrap_pc", pc_w, 32'hFFFF_FFFC);

        // addi x1,x0,5 with zero wait states; the wrap instance fetches at 0xFFFFFFFC.
        reset = 1'b0;
        mem_rdata = 32'h0050_0093;
        #1;
        check("addi_fetch_req", {30'b0, req_a, we_a}, 32'h2);
        check("addi_fetch_addr", addr_a, 32'h0000_1000);
        check("wrap_fetch_addr", addr_w, 32'hFFFF_FFFC);
        cyc();
        mem_ready = 1'b0;
        #1;
        check("addi_instr", instr_a, 32'h0050_0093);
        check("addi_old_pc", opc_a, 32'h0000_1000);
        check("addi_pc", pc_a, 32'h0000_1004);
        check("decode_selects", {25'b0, sa_a, sb_a, imm_a}, {25'b0, 2'b01, 2'b01, 3'd2});
        check("wrap_pc", pc_w, 32'h0000_0000);
        check("wrap_old_pc", opc_w, 32'hFFFF_FFFC);
        cyc();
        check("exec_i_selects", {21'b0, sa_a, sb_a, imm_a, op_a}, {21'b0, 2'b10, 2'b01, 3'd0, 4'd3});
        check("exec_i_no_write", {31'b0, rw_a}, 32'h0);
        cyc();
        check("addi_wb", {29'b0, rw_a, rs_a}, {29'b0, 1'b1, 2'b00});
        cyc();
        check("addi_after_rw", {31'b0, rw_a}, 32'h0);
        check("addi_retired", ret_a, 32'd1);
        check("addi_next_fetch", addr_a, 32'h0000_1004);

        // lw with three wait states in MEM_RD.
        do_reset();
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_A103;
        #1;
        cyc();
        mem_ready = 1'b0;
        #1;
        cyc();
        result = 32'h0000_2040;
        #1;
        check("lw_adr_selects", {25'b0, sa_a, sb_a, imm_a}, {25'b0, 2'b10, 2'b01, 3'd0});
        check("lw_adr_no_req", {31'b0, req_a}, 32'h0);
        for (int w = 0; w < 4; w++) begin
            cyc();
            if (w == 3) mem_ready = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
            #1;
            check("lw_rd_req", {30'b0, req_a, we_a}, 32'h2);
            check("lw_rd_addr", addr_a, 32'h0000_2040);
        end
        cyc();
        mem_ready = 1'b0;
        #1;
        check("lw_wb", {29'b0, rw_a, rs_a}, {29'b0, 1'b1, 2'b01});
        check("lw_wb_no_req", {31'b0, req_a}, 32'h0);
        check("lw_not_yet_retired", ret_a, 32'd0);
        cyc();
        check("lw_retired_8cyc", ret_a, 32'd1);
        check("lw_back_to_fetch", {31'b0, req_a}, 32'h1);

        // Branch table: each branch is FETCH, DECODE (target on result), BRANCH.
        do_reset();
        pc_exp = 32'h0000_1000;
        for (int i = 0; i < 7; i++) begin
            mem_ready = 1'b1;
            mem_rdata = {17'b0, br_tab[i].f3, 5'b0, 7'b1100011};
            #1;
            check("br_fetch_addr", addr_a, pc_exp);
            cyc();
            mem_ready = 1'b0;
            result = pc_exp + 32'h10;
            #1;
            cyc();
            alu_zero = br_tab[i].z;
            alu_carry = br_tab[i].c;
            alu_sign = br_tab[i].s;
            alu_overflow = br_tab[i].v;
            #1;
            check("br_selects", {22'b0, sa_a, sb_a, op_a, rw_a}, {22'b0, 2'b10, 2'b00, 4'd1, 1'b0});
            cyc();
            pc_next = br_tab[i].taken ? pc_exp + 32'h10 : pc_exp + 32'h4;
            check("br_pc", pc_a, pc_next);
            check("br_retired", ret_a, 32'(i + 1));
            pc_exp = pc_next;
        end
        alu_zero = 1'b0;
        alu_carry = 1'b0;
        alu_sign = 1'b0;
        alu_overflow = 1'b0;

        // jal x0,8: target from the live ALU result, link via ALU_WB.
        do_reset();
        mem_ready = 1'b1;
        mem_rdata = 32'h0080_006F;
        #1;
        cyc();
        mem_ready = 1'b0;
        #1;
        cyc();
        result = 32'h0000_1008;
        #1;
        check("jal_selects", {23'b0, sa_a, sb_a, rs_a, imm_a}, {23'b0, 2'b01, 2'b01, 2'b10, 3'd4});
        cyc();
        result = 32'h0000_1004;
        #1;
        check("jal_pc", pc_a, 32'h0000_1008);
        check("jal_link_wb", {25'b0, rw_a, sa_a, sb_a, rs_a}, {25'b0, 1'b1, 2'b01, 2'b10, 2'b10});
        cyc();
        check("jal_fetch_addr", addr_a, 32'h0000_1008);
        check("jal_retired", ret_a, 32'd1);

        // Illegal opcode 0x7F: one instance halts, the other retires a NOP.
        do_reset();
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_007F;
        #1;
        cyc();
        check("ill_pulse_halt", {31'b0, ill_a}, 32'h1);
        check("ill_pulse_nop", {31'b0, ill_n}, 32'h1);
        cyc();
        mem_ready = 1'b0;
        #1;
        check("ill_halted", {30'b0, hlt_a, ill_a}, 32'h2);
        check("ill_halt_no_retire", ret_a, 32'd0);
        check("ill_nop_retired", ret_n, 32'd1);
        check("ill_nop_clear", {31'b0, ill_n}, 32'h0);
        check("ill_nop_fetch", {req_n, addr_n[30:0]}, {1'b1, 31'h0000_1004});
        for (int k = 0; k < 20; k++) begin
            cyc();
            mem_ready = 1'b1;
            #1;
            check("halt_quiet", {29'b0, req_a, rw_a, hlt_a}, 32'h1);
        end

        // Reset during a MEM_WR wait, with mem_ready high in the reset cycle.
        do_reset();
        mem_ready = 1'b1;
        mem_rdata = 32'h0020_A023;
        #1;
        cyc();
        mem_ready = 1'b0;
        #1;
        cyc();
        result = 32'h0000_3000;
        #1;
        check("sw_adr_imm", {29'b0, imm_a}, 32'd1);
        cyc();
        check("sw_wr_req", {30'b0, req_a, we_a}, 32'h3);
        check("sw_wr_addr", addr_a, 32'h0000_3000);
        cyc();
        check("sw_wr_wait_addr", addr_a, 32'h0000_3000);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        cyc();
        check("sw_rst_req", {30'b0, req_a, we_a}, 32'h0);
        check("sw_rst_pc", pc_a, 32'h0000_1000);
        check("sw_rst_no_retire", ret_a, 32'd0);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("sw_rst_fetch", {req_a, we_a, addr_a[29:0]}, {1'b1, 1'b0, 30'h0000_1000});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of PC, address and result paths.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h1000: PC value after reset.
REQ-003 SHALL have parameter HALT_ON_ILLEGAL, default 1: 1 = an illegal opcode halts the core, 0 = it retires as a NOP.
REQ-004 SHALL use one clock; reset is synchronous and active-high. Ports: clk  in  1  clock; reset  in  1  sync active-high reset.
REQ-005 SHALL have ports:
  mem_req  out  1  memory request.
  mem_we  out  1  write strobe.
  mem_addr  out  XLEN  memory address.
  mem_ready  in  1  access complete.
  mem_rdata  in  32  read data.
REQ-006 SHALL have ports:
  result  in  XLEN  datapath result bus.
  alu_zero, alu_carry, alu_sign, alu_overflow  in  1 each  ALU flags.
REQ-007 SHALL have ports:
  pc  out  XLEN.
  old_pc  out  XLEN.
  instr  out  32  instruction register.
  retired  out  XLEN  retired-instruction count.
REQ-008 SHALL have ports:
  alu_src_a  out  2  (00 pc, 01 old_pc, 10 rs1, 11 zero).
  alu_src_b  out  2  (00 rs2, 01 imm, 10 const 4).
  result_src  out  2  (00 alu_reg, 01 mem data, 10 alu_result).
  imm_src  out  3  (I,S,B,U,J).
  alu_op  out  4.
  reg_write  out  1.
  halted  out  1.
  illegal  out  1.

Function
REQ-009 SHALL implement states FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, JALR, LUI, AUIPC, HALT.
REQ-010 SHALL, in FETCH, drive mem_req=1, mem_we=0 and mem_addr=pc, and hold them until mem_ready=1.
REQ-011 SHALL, on the FETCH cycle with mem_ready=1, load instr<=mem_rdata, old_pc<=pc and pc<=pc+4 (mod 2^XLEN), then enter DECODE.
REQ-012 SHALL spend exactly one cycle in DECODE, then dispatch on opcode:
  0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011/0100011 -> MEM_ADR; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; 0010111 -> AUIPC.
REQ-013 SHALL, in DECODE, drive alu_src_a=01, alu_src_b=01, imm_src=B, so that alu_reg holds the branch target old_pc+imm.
REQ-014 SHALL, for EXEC_R/EXEC_I/LUI/AUIPC, go to ALU_WB next; ALU_WB asserts reg_write=1 with result_src=00 for one cycle, then returns to FETCH.
REQ-015 SHALL, in MEM_ADR, compute rs1+imm; a load then enters MEM_RD and a store enters MEM_WR.
REQ-016 SHALL, in MEM_RD/MEM_WR, drive mem_req=1 with mem_addr=result, and mem_we=1 only in MEM_WR; it stays in the state while mem_ready=0.
REQ-017 SHALL, after a load's mem_ready, enter MEM_WB (reg_write=1, result_src=01, one cycle) then FETCH; after a store's mem_ready it returns to FETCH directly.
REQ-018 SHALL, in BRANCH, compare rs1-rs2 and evaluate funct3 as follows, loading pc<=alu_reg if taken:
  beq zero; bne !zero; blt sign^overflow; bge !(sign^overflow); bltu !carry; bgeu carry.
  funct3 010/011 is illegal.
REQ-019 SHALL, in JAL/JALR, load pc<=target (old_pc+imm, or (rs1+imm)&~1 for JALR) and write old_pc+4 to rd, then enter FETCH.
REQ-020 SHALL give a cycle count per instruction with mem_ready tied 1: ALU/LUI/AUIPC 4, load 5, store 4, branch 3, JAL/JALR 4; each memory wait cycle adds exactly 1.
REQ-021 SHALL increment retired by 1 on the final cycle of every retired instruction (including NOPs); it wraps at 2^XLEN.
REQ-022 SHALL handle illegal opcode/funct3 as follows: illegal=1 for one cycle, then HALT if HALT_ON_ILLEGAL, else retire as a NOP.
REQ-023 SHALL, in HALT, hold halted=1, mem_req=0 and reg_write=0 indefinitely; only reset exits.
REQ-024 SHALL keep mem_req, mem_we and mem_addr stable from request assertion until the mem_ready cycle.

Reset
REQ-025 SHALL, on reset, set state=FETCH, pc=RESET_VECTOR, old_pc=0, instr=0, retired=0, and all strobes/selects, halted and illegal to 0.
REQ-026 SHALL, on reset asserted mid-transaction (any wait state), drop mem_req on the next cycle; the pending access is abandoned and nothing is written back.
REQ-027 SHALL give reset priority over mem_ready in the same cycle.

Structure
REQ-028 SHALL place the state enum, opcode constants, alu_op encoding and mux-select constants in shared package mc_pkg.
REQ-029 SHALL put branch condition evaluation in sub-module branch_eval (funct3 plus flags -> taken, illegal).

Verification
REQ-030 Reset, then mem_ready=1, instr 0x00500093 (addi x1,x0,5) -> reg_write pulses at cycle 4; pc=0x1004; retired=1.
REQ-031 Load 0x0000A103 with mem_ready low 3 cycles in MEM_RD -> mem_addr/mem_req stable 4 cycles; total 8 cycles; result_src=01 at writeback.
REQ-032 beq with alu_zero=1, target 0x1010 -> pc=0x1010 after 3 cycles; repeat with alu_zero=0 -> pc=old_pc+4.
REQ-033 Opcode 0x7F with HALT_ON_ILLEGAL=1 -> illegal pulse, halted=1, mem_req stays 0 for 20 cycles; with 0 -> retired increments and fetch resumes.
REQ-034 Reset asserted during a MEM_WR wait -> mem_req=0 next cycle; pc=0x1000, state FETCH.
REQ-035 XLEN=32, pc=0xFFFFFFFC fetch -> pc wraps to 0x00000000.
